btn_debounce_array: RTL and testbench
=====================================

# btn_debounce_array

Parametrised multi-channel push-button debouncer for the FPGA board inputs of the MIPS-based processor: step/run buttons, reset request, switches. Each channel synchronises its raw pin, filters bounce with a per-channel stability counter driven by a shared prescaler tick, and produces a clean level, one-cycle rise/fall pulses, and a sticky press flag cleared by a consumer acknowledge. It replaces the single-channel fixed-ratio debouncer and sits between the top-level pins and the processor control/step logic.

## Interface
- N_CH, default 4: number of independent channels (1..32).
- TICK_DIV, default 50000: prescaler period in clk cycles (≥2); one tick pulse per period.
- STABLE_TICKS, default 4: consecutive ticks an input must differ from the current level before the level flips (≥1).
- ACTIVE_LOW, default 0: when 1, raw inputs are inverted, so the pressed state is pin low.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  N_CH  raw asynchronous pin inputs.
- ack  input  N_CH  per-channel clear for press_pend.
- db_level  output  N_CH  debounced logical level; 1 = pressed.
- db_rise  output  N_CH  one-cycle pulse when db_level goes 0→1.
- db_fall  output  N_CH  one-cycle pulse when db_level goes 1→0.
- press_pend  output  N_CH  sticky flag, set by rise, cleared by ack.

## Operation
- Inversion: logical input = btn_raw XOR ACTIVE_LOW, applied before the synchroniser.
- Synchroniser: a 2-FF chain per channel. Both stages reset to logical 0, so an idle pin produces no edge after reset.
- Prescaler: a shared counter tdiv, width clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps. tick = (tdiv == TICK_DIV-1).
- Per-channel counter cnt, width clog2(STABLE_TICKS+1):
  - If sync_out == db_level: cnt ← 0 on every cycle, tick or not.
  - Else if tick and cnt == STABLE_TICKS-1: db_level ← sync_out, cnt ← 0.
  - Else if tick: cnt ← cnt+1.
  - Otherwise cnt holds.
- db_rise and db_fall are registered. They assert in the same cycle the new db_level is first visible, for exactly one cycle.
- press_pend: set by db_rise, cleared by ack. If set and ack occur in the same cycle, set wins.
- Channels are fully independent. There is no arbitration between them.

## Timing
- Reset values: db_level, db_rise, db_fall, press_pend, cnt, tdiv and the sync FFs are all 0. Reset takes effect asynchronously, mid-count or not.
- Latency from pin change to db_level:
  - 2 cycles of synchronisation, then STABLE_TICKS ticks.
  - The first of those ticks occurs anywhere from 1 to TICK_DIV cycles after sync_out changes.
  - Total is 2+(STABLE_TICKS-1)·TICK_DIV+1 to 2+STABLE_TICKS·TICK_DIV cycles.
- Any sync_out sample that matches db_level restarts the count. A glitch must therefore persist unbroken across STABLE_TICKS ticks to pass.
- Minimum separation between consecutive edges on one channel is STABLE_TICKS ticks.
- ack has no latency requirement; a cleared press_pend reads 0 on the next cycle.

## Structure
- Shared package holds `db_pkg`: constants TDIV_W and CNT_W computed via clog2, and the default TICK_DIV and STABLE_TICKS values for the board clock.
- Sub-module `db_channel` contains sync, cnt, level, edge and pending logic for one channel. Its inputs are clk, rst, tick, raw bit and ack bit.
- The top module holds the prescaler and a generate loop of N_CH `db_channel` instances.

## Test plan
All scenarios use N_CH=3, TICK_DIV=5, STABLE_TICKS=4, ACTIVE_LOW=0.
- **Clean press:** drive btn_raw[0]=1 and hold for 60 cycles.
  - db_level[0] rises 18–22 cycles after the pin edge.
  - db_rise[0] is high exactly 1 cycle, coincident with the level edge.
  - press_pend[0] is set; channels 1 and 2 stay 0.
- **Bounce:** toggle btn_raw[1] every 3 cycles for 40 cycles, then hold it at 1.
  - Exactly one db_rise[1] pulse and no db_fall[1].
  - The level rises 18–22 cycles after the final toggle.
- **Glitch rejection:** with db_level[2]=1, drive btn_raw[2]=0 for 12 cycles, then back to 1.
  - db_level[2] stays 1 and no pulses occur.
- **Ack handshake:** assert ack[0] alone, then assert ack[0] in the same cycle as a new db_rise[0].
  - The first ack clears press_pend[0] on the next cycle.
  - In the simultaneous case, press_pend[0] stays 1.
- **Reset mid-operation:** assert rst while cnt[0]=2 and btn_raw[0]=1.
  - All outputs go 0 immediately.
  - After release with the pin held, the level rises after a full 18–22 cycle latency.
- **Active-low:** with ACTIVE_LOW=1 and pins idle high through reset, no pulses occur after reset release.
  - Pulling btn_raw[0] low gives db_level[0]=1 after 18–22 cycles.

Source files
------------

// File: rtl/db_pkg.sv
// Shared constants and helpers for the push-button debouncer array.
// Defaults are sized for the board clock; instances may override them.
package db_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;

  localparam int TDIV_W = $clog2(DEF_TICK_DIV);
  localparam int CNT_W  = $clog2(DEF_STABLE_TICKS + 1);

  // Counter width for a range of v states, never narrower than one bit.
  function automatic int cnt_width(input int v);
    cnt_width = (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-FF synchroniser, tick-driven stability counter,
// debounced level, registered rise/fall pulses and a sticky press flag.
module db_channel
  import db_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int CW           = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  input  logic ack,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pend
);

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          rise_next;
  logic          fall_next;
  logic          pend_next;

  // Inversion happens ahead of the chain so an idle active-low pin reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw ^ ACTIVE_LOW;
      sync_b <= sync_a;
    end
  end

  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (sync_b == level) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        cnt_next   = '0;
        level_next = sync_b;
        rise_next  = sync_b;
        fall_next  = ~sync_b;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Set from the registered rise so an ack arriving with the pulse loses.
  assign pend_next = rise | (pend & ~ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
      pend  <= pend_next;
    end
  end

endmodule

// File: rtl/btn_debounce_array.sv
// Multi-channel push-button debouncer: one shared tick prescaler feeding
// N_CH independent debounce channels.
module btn_debounce_array
  import db_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall,
  output logic [N_CH-1:0] press_pend
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam int CW = cnt_width(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TDIV_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tdiv;
  logic          tick;

  assign tick = (tdiv == TDIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdiv <= '0;
    end else if (tick) begin
      tdiv <= '0;
    end else begin
      tdiv <= tdiv + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    db_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .CW          (CW)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (btn_raw[gi]),
      .ack  (ack[gi]),
      .level(db_level[gi]),
      .rise (db_rise[gi]),
      .fall (db_fall[gi]),
      .pend (press_pend[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array: a vector table plus hand-written
// sequences for latency, bounce, glitch, ack, async reset and active-low.
module tb_btn_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw, ack, db_level, db_rise, db_fall, press_pend;
  logic [2:0] btn_raw_al, ack_al, lvl_al, rise_al, fall_al, pend_al;

  always #5 clk = ~clk;

  btn_debounce_array #(.N_CH(3), .TICK_DIV(5), .STABLE_TICKS(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .ack(ack),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall), .press_pend(press_pend)
  );

  btn_debounce_array #(.N_CH(3), .TICK_DIV(5), .STABLE_TICKS(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_al), .ack(ack_al),
    .db_level(lvl_al), .db_rise(rise_al), .db_fall(fall_al), .press_pend(pend_al)
  );

  typedef struct {
    logic [2:0] raw;
    logic [2:0] ackv;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] pend;
  } vec_t;

  vec_t       tbl [6];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_level = '0;
  logic [2:0] rise_seen, fall_seen;
  logic [2:0] al_seen = '0;
  int         rise_cnt [3];
  int         fall_cnt [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, val, lo, hi);
    end
  endtask

  // Advance to the next falling edge; pulses must coincide with level edges.
  task automatic step();
    @(negedge clk);
    if (mon_en) begin
      check("rise_vs_edge", db_rise, db_level & ~prev_level);
      check("fall_vs_edge", db_fall, ~db_level & prev_level);
      rise_seen |= db_rise;
      fall_seen |= db_fall;
      for (int c = 0; c < 3; c++) begin
        if (db_rise[c]) rise_cnt[c]++;
        if (db_fall[c]) fall_cnt[c]++;
      end
    end
    al_seen    |= rise_al | fall_al;
    prev_level = db_level;
  endtask

  task automatic clear_counts();
    rise_seen = '0;
    fall_seen = '0;
    for (int c = 0; c < 3; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  task automatic wait_level(input int ch, input logic val, input bit al, output int lat);
    logic [2:0] lv;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      lat++;
      lv = al ? lvl_al : db_level;
      if (lv[ch] == val) return;
    end
    lat = 99;
  endtask

  initial begin
    int   lat;
    bit   found;
    logic lvl_and;

    tbl[0] = '{raw: 3'b000, ackv: 3'b000, lvl: 3'b000, rise: 3'b000, fall: 3'b111, pend: 3'b111};
    tbl[1] = '{raw: 3'b101, ackv: 3'b111, lvl: 3'b101, rise: 3'b101, fall: 3'b000, pend: 3'b000};
    tbl[2] = '{raw: 3'b110, ackv: 3'b000, lvl: 3'b110, rise: 3'b010, fall: 3'b001, pend: 3'b010};
    tbl[3] = '{raw: 3'b011, ackv: 3'b010, lvl: 3'b011, rise: 3'b001, fall: 3'b100, pend: 3'b001};
    tbl[4] = '{raw: 3'b100, ackv: 3'b000, lvl: 3'b100, rise: 3'b100, fall: 3'b011, pend: 3'b101};
    tbl[5] = '{raw: 3'b000, ackv: 3'b101, lvl: 3'b000, rise: 3'b000, fall: 3'b100, pend: 3'b000};

    rst        = 1'b1;
    btn_raw    = '0;
    ack        = '0;
    btn_raw_al = 3'b111;
    ack_al     = '0;
    clear_counts();
    step();
    step();
    check("reset_level", db_level, 3'b000);
    check("reset_rise", db_rise, 3'b000);
    check("reset_fall", db_fall, 3'b000);
    check("reset_pend", press_pend, 3'b000);
    check("reset_level_al", lvl_al, 3'b000);
    rst        = 1'b0;
    prev_level = db_level;
    mon_en     = 1'b1;

    // Idle pins: nothing may happen.
    repeat (30) step();
    check("idle_level", db_level, 3'b000);
    check("idle_rise_seen", rise_seen, 3'b000);

    // Clean press on channel 0.
    clear_counts();
    btn_raw = 3'b001;
    wait_level(0, 1'b1, 1'b0, lat);
    check_range("press_latency", lat, 18, 22);
    check("press_rise_at_edge", db_rise, 3'b001);
    step();
    check("press_rise_one_cycle", db_rise, 3'b000);
    check("press_pend_set", press_pend, 3'b001);
    repeat (38) step();
    check("press_level_hold", db_level, 3'b001);
    check("press_rise_count", rise_cnt[0], 1);

    // Ack alone clears on the next cycle.
    ack = 3'b001;
    step();
    ack = 3'b000;
    check("ack_clears", press_pend, 3'b000);

    // Ack coinciding with a fresh rise: set wins.
    btn_raw = 3'b000;
    wait_level(0, 1'b0, 1'b0, lat);
    check_range("release_latency", lat, 18, 22);
    repeat (5) step();
    btn_raw = 3'b001;
    wait_level(0, 1'b1, 1'b0, lat);
    check("ack_rise_visible", db_rise[0], 1'b1);
    ack = 3'b001;
    step();
    ack = 3'b000;
    check("ack_same_cycle_set_wins", press_pend[0], 1'b1);
    step();
    check("ack_same_cycle_held", press_pend[0], 1'b1);

    // Bounce on channel 1: toggles every 3 cycles, last toggle lands at 1.
    clear_counts();
    for (int i = 0; i < 13; i++) begin
      btn_raw[1] = ~btn_raw[1];
      if (i < 12) repeat (3) step();
    end
    wait_level(1, 1'b1, 1'b0, lat);
    check_range("bounce_latency", lat, 18, 22);
    repeat (20) step();
    check("bounce_rise_count", rise_cnt[1], 1);
    check("bounce_fall_count", fall_cnt[1], 0);

    // Glitch rejection on channel 2: 12-cycle dip spans at most 3 ticks.
    btn_raw[2] = 1'b1;
    wait_level(2, 1'b1, 1'b0, lat);
    check_range("ch2_latency", lat, 18, 22);
    repeat (5) step();
    clear_counts();
    lvl_and    = 1'b1;
    btn_raw[2] = 1'b0;
    for (int i = 0; i < 42; i++) begin
      if (i == 12) btn_raw[2] = 1'b1;
      step();
      lvl_and &= db_level[2];
    end
    check("glitch_level_held", lvl_and, 1'b1);
    check("glitch_no_rise", rise_cnt[2], 0);
    check("glitch_no_fall", fall_cnt[2], 0);
    check("pre_table_pend", press_pend, 3'b111);

    // Vector table: each entry is held 30 cycles, long enough to settle.
    for (int v = 0; v < 6; v++) begin
      clear_counts();
      btn_raw = tbl[v].raw;
      ack     = tbl[v].ackv;
      repeat (30) step();
      ack = 3'b000;
      check($sformatf("vec%0d_level", v), db_level, tbl[v].lvl);
      check($sformatf("vec%0d_rise", v), rise_seen, tbl[v].rise);
      check($sformatf("vec%0d_fall", v), fall_seen, tbl[v].fall);
      check($sformatf("vec%0d_pend", v), press_pend, tbl[v].pend);
    end

    // Asynchronous reset while channel 0 is mid-count.
    btn_raw = 3'b010;
    repeat (30) step();
    check("prereset_level", db_level, 3'b010);
    btn_raw = 3'b111;
    found   = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (u_dut.g_ch[0].u_ch.cnt == 3'd2) found = 1'b1;
    end
    check("cnt_reached_2", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", db_level, 3'b000);
    check("async_rst_pend", press_pend, 3'b000);
    check("async_rst_pulses", {db_rise, db_fall}, 6'b0);
    prev_level = '0;
    step();
    step();
    rst = 1'b0;
    clear_counts();
    wait_level(0, 1'b1, 1'b0, lat);
    check_range("post_reset_latency", lat, 18, 22);
    repeat (3) step();
    check("post_reset_level", db_level, 3'b111);

    // Active-low instance: idle-high pins through reset yield nothing.
    rst = 1'b1;
    prev_level = '0;
    step();
    rst     = 1'b0;
    al_seen = '0;
    repeat (30) step();
    check("al_idle_no_pulse", al_seen, 3'b000);
    check("al_idle_level", lvl_al, 3'b000);
    btn_raw_al = 3'b110;
    wait_level(0, 1'b1, 1'b1, lat);
    check_range("al_press_latency", lat, 18, 22);
    check("al_press_level", lvl_al, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
